compare_sequencer: RTL and testbench



---
 rtl/compare_pkg.sv | 14 +
 rtl/compare_step.sv | 18 +
 rtl/compare_sequencer.sv | 131 +++++++++++++
 tb/tb_compare_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared constants and state type for the bit-serial magnitude comparator.
package compare_pkg;

  localparam int WIDTH  = 8;
  localparam int NIBBLE = 4;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/compare_step.sv
// One MSB-first magnitude-compare step; time-shared across all operand bits.
module compare_step (
  input  logic a,
  input  logic b,
  input  logic lt_in,
  input  logic gt_in,
  input  logic eq_in,
  output logic lt_out,
  output logic gt_out,
  output logic eq_out
);

  // Once eq drops, lt/gt are frozen: the first differing bit decides.
  assign gt_out = gt_in | (eq_in & a & ~b);
  assign lt_out = lt_in | (eq_in & ~a & b);
  assign eq_out = eq_in & ~(a ^ b);

endmodule

// File: rtl/compare_sequencer.sv
// Push-button operand loader and bit-serial compare sequencer.
// Optional COMPARE_EARLY_EXIT_EN ends the run at the first differing bit.
module compare_sequencer
  import compare_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pb,
  input  logic [3:0]       y,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  logic [3:0]       pb_sync;
  logic [3:0]       pb_prev;
  logic [3:0]       pb_rise;
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IDX_W-1:0] idx;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             lt_out;
  logic             gt_out;
  logic             eq_out;
  logic             last_step;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], pb[gi]};
      end
      assign pb_sync[gi] = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pb_prev <= '0;
    else     pb_prev <= pb_sync;
  end

  assign pb_rise = pb_sync & ~pb_prev;

  compare_step u_step (
    .a      (a_sh[WIDTH-1]),
    .b      (b_sh[WIDTH-1]),
    .lt_in  (lt),
    .gt_in  (gt),
    .eq_in  (eq),
    .lt_out (lt_out),
    .gt_out (gt_out),
    .eq_out (eq_out)
  );

`ifdef COMPARE_EARLY_EXIT_EN
  assign last_step = (idx == '0) || !eq_out;
`else
  assign last_step = (idx == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b1;
      l     <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Snapshot sees the pre-load operands when a load and start coincide.
          if (pb_rise[0]) a_q[NIBBLE-1:0]     <= y;
          if (pb_rise[1]) a_q[WIDTH-1:NIBBLE] <= y;
          if (pb_rise[2]) b_q[NIBBLE-1:0]     <= y;
          if (pb_rise[3]) b_q[WIDTH-1:NIBBLE] <= y;
          if (start) begin
            a_sh  <= a_q;
            b_sh  <= b_q;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b1;
            idx   <= IDX_W'(WIDTH - 1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          lt   <= lt_out;
          gt   <= gt_out;
          eq   <= eq_out;
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          b_sh <= {b_sh[WIDTH-2:0], 1'b0};
          idx  <= idx - 1'b1;
          if (last_step) state <= FINISH;
        end
        FINISH: begin
          l     <= lt;
          g     <= gt;
          e     <= eq;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_sequencer.sv
// Randomised and directed bench for compare_sequencer with a cycle-level behavioural model.
module tb_compare_sequencer;

  localparam int S = 2;

`ifdef COMPARE_EARLY_EXIT_EN
  localparam int LAT_80_7F = 2;
  localparam int LAT_01_02 = 8;
`else
  localparam int LAT_80_7F = 9;
  localparam int LAT_01_02 = 9;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] y;
  logic       start;
  logic       busy, done, l, g, e;
  logic [7:0] a_q, b_q;

  int checks   = 0;
  int failures = 0;

  compare_sequencer #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb),
    .y     (y),
    .start (start),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .g     (g),
    .e     (e),
    .a_q   (a_q),
    .b_q   (b_q)
  );

  always #5 clk = ~clk;

  // Behavioural model: operand registers, pending result countdown, pb sample history.
  logic [7:0] a_m, b_m, sa, sb;
  logic       busy_m, done_m, l_m, g_m, e_m;
  int         remain;
  logic [3:0] hist [S+2];

  function automatic int first_mismatch(logic [7:0] av, logic [7:0] bv);
    for (int i = 7; i >= 0; i--)
      if (av[i] != bv[i]) return i;
    return -1;
  endfunction

  function automatic int latency(logic [7:0] av, logic [7:0] bv);
    int fm;
    fm = first_mismatch(av, bv);
`ifdef COMPARE_EARLY_EXIT_EN
    return (fm < 0) ? 9 : 9 - fm;
`else
    return (fm < -1) ? 0 : 9;
`endif
  endfunction

  task automatic model_reset();
    a_m = 8'h00; b_m = 8'h00; sa = 8'h00; sb = 8'h00;
    busy_m = 1'b0; done_m = 1'b0;
    l_m = 1'b0; g_m = 1'b0; e_m = 1'b1;
    remain = 0;
    for (int i = 0; i < S + 2; i++) hist[i] = 4'h0;
  endtask

  task automatic model_step();
    logic [3:0] rise;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pb;
      // A press is seen S+1 edges after pb first samples high.
      rise = hist[S] & ~hist[S+1];
      done_m = 1'b0;
      if (!busy_m) begin
        if (start) begin
          sa = a_m; sb = b_m;
          remain = latency(sa, sb);
          busy_m = 1'b1;
        end
        if (rise[0]) a_m[3:0] = y;
        if (rise[1]) a_m[7:4] = y;
        if (rise[2]) b_m[3:0] = y;
        if (rise[3]) b_m[7:4] = y;
      end else begin
        remain--;
        if (remain == 0) begin
          busy_m = 1'b0;
          done_m = 1'b1;
          l_m = (sa < sb);
          g_m = (sa > sb);
          e_m = (sa == sb);
        end
      end
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_q", a_q, a_m);
    chk("b_q", b_q, b_m);
    chk("busy", {7'd0, busy}, {7'd0, busy_m});
    chk("done", {7'd0, done}, {7'd0, done_m});
    chk("l", {7'd0, l}, {7'd0, l_m});
    chk("g", {7'd0, g}, {7'd0, g_m});
    chk("e", {7'd0, e}, {7'd0, e_m});
    chk("onehot_lge", {6'd0, 2'(l) + 2'(g) + 2'(e)}, 8'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic press(int btn, logic [3:0] val);
    y = val;
    pb[btn] = 1'b1;
    cycle();
    cycle();
    pb[btn] = 1'b0;
    repeat (S + 1) cycle();
  endtask

  task automatic load_operands(logic [7:0] av, logic [7:0] bv);
    press(0, av[3:0]);
    press(1, av[7:4]);
    press(2, bv[3:0]);
    press(3, bv[7:4]);
    chk("load_a", a_q, av);
    chk("load_b", b_q, bv);
  endtask

  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (1) begin
      cycle();
      n++;
      if (busy) busy_cnt++;
      if (done) break;
      if (n >= 20) begin
        failures++;
        $display("FAIL wait_done: no done within %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic run_cmp(string name, logic [7:0] av, logic [7:0] bv, int exp_lat,
                         logic exp_l, logic exp_g, logic exp_e);
    int n, bc;
    load_operands(av, bv);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(n, bc);
    bc += 1;  // busy was already high in the start cycle
    chk({name, "_latency"}, 8'(n), 8'(exp_lat));
    chk({name, "_busy_cycles"}, 8'(bc), 8'(exp_lat));
    chk({name, "_l"}, {7'd0, l}, {7'd0, exp_l});
    chk({name, "_g"}, {7'd0, g}, {7'd0, exp_g});
    chk({name, "_e"}, {7'd0, e}, {7'd0, exp_e});
  endtask

  initial begin
    int n, bc;
    rst = 1'b0; pb = 4'h0; y = 4'h0; start = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all();
    cycle();
    #1 rst = 1'b0;

    run_cmp("eq_5a", 8'h5A, 8'h5A, 9, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while idle clears the loaded operands at once.
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("idle_rst_a", a_q, 8'h00);
    chk("idle_rst_busy", {7'd0, busy}, 8'd0);
    check_all();
    cycle();
    #1 rst = 1'b0;

    run_cmp("gt_80_7f", 8'h80, 8'h7F, LAT_80_7F, 1'b0, 1'b1, 1'b0);
    run_cmp("lt_01_02", 8'h01, 8'h02, LAT_01_02, 1'b1, 1'b0, 1'b0);

    // Presses and start while busy are dropped.
    start = 1'b1;
    cycle();
    start = 1'b0;
    y = 4'hF;
    pb[0] = 1'b1;
    cycle();
    pb[0] = 1'b0;
    cycle();
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(n, bc);
    repeat (4) cycle();
    chk("busy_press_a_q", a_q, 8'h01);
    chk("no_second_run", {7'd0, busy}, 8'd0);

    // Press edge and start land in the same idle cycle.
    y = 4'hF;
    pb[0] = 1'b1;
    cycle();
    pb[0] = 1'b0;
    repeat (S - 1) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("same_cycle_a_q", a_q, 8'h0F);
    wait_done(n, bc);
    chk("same_cycle_old_l", {7'd0, l}, 8'd1);

    // Reset in the middle of a run aborts it.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("run_rst_busy", {7'd0, busy}, 8'd0);
    chk("run_rst_e", {7'd0, e}, 8'd1);
    check_all();
    cycle();
    cycle();
    #1 rst = 1'b0;
    repeat (12) cycle();

    // Random buttons, nibbles and start requests against the model.
    for (int i = 0; i < 4000; i++) begin
      pb[0] = ($urandom_range(0, 5) == 0);
      pb[1] = ($urandom_range(0, 5) == 0);
      pb[2] = ($urandom_range(0, 5) == 0);
      pb[3] = ($urandom_range(0, 5) == 0);
      y     = 4'($urandom);
      start = ($urandom_range(0, 9) == 0);
      cycle();
    end
    pb = 4'h0;
    start = 1'b0;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
